// File: rtl/shift_right_round_even.sv
// Sequential right-shift denormalizer: shifts 2 bits/cycle (1 on an odd tail),
// gathers guard/round/sticky and rounds to nearest even.
module shift_right_round_even #(
  parameter int WIDTH = 24,
  parameter int SA_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [SA_W-1:0]  sa,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] b,
  output logic             inexact
);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] frac, frac_nx, b_nx;
  logic             g, r, s, g_nx, r_nx, s_nx;
  logic [SA_W-1:0]  cnt, cnt_nx;
  logic             done_nx, inexact_nx, inc;

  assign busy = (state != IDLE);
  assign inc  = g & (r | s | frac[0]);

  always_comb begin
    state_nx   = state;
    frac_nx    = frac;
    g_nx       = g;
    r_nx       = r;
    s_nx       = s;
    cnt_nx     = cnt;
    b_nx       = b;
    inexact_nx = inexact;
    done_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          frac_nx  = a;
          g_nx     = 1'b0;
          r_nx     = 1'b0;
          s_nx     = 1'b0;
          cnt_nx   = sa;
          state_nx = (sa == '0) ? ROUND : SHIFT;
        end
      end
      SHIFT: begin
        // cnt is never zero here: sa==0 bypasses straight to ROUND
        if (cnt >= SA_W'(2)) begin
          frac_nx = frac >> 2;
          g_nx    = frac[1];
          r_nx    = frac[0];
          s_nx    = s | g | r;
          cnt_nx  = cnt - SA_W'(2);
        end else begin
          frac_nx = frac >> 1;
          g_nx    = frac[0];
          r_nx    = g;
          s_nx    = s | r;
          cnt_nx  = '0;
        end
        if (cnt_nx == '0) state_nx = ROUND;
      end
      ROUND: begin
        b_nx       = frac + WIDTH'(inc);
        inexact_nx = g | r | s;
        done_nx    = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      frac    <= '0;
      g       <= 1'b0;
      r       <= 1'b0;
      s       <= 1'b0;
      cnt     <= '0;
      b       <= '0;
      inexact <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      frac    <= frac_nx;
      g       <= g_nx;
      r       <= r_nx;
      s       <= s_nx;
      cnt     <= cnt_nx;
      b       <= b_nx;
      inexact <= inexact_nx;
      done    <= done_nx;
    end
  end

endmodule

// File: tb/tb_shift_right_round_even.sv
// Bench for shift_right_round_even: directed table, random ops against an
// arithmetic rounding model, plus busy/reset/back-to-back sequences.
module tb_shift_right_round_even;

  logic        clk = 1'b0;
  logic        rst, start, busy, done, inexact;
  logic [23:0] a, b;
  logic [4:0]  sa;

  int checks = 0;
  int errors = 0;

  shift_right_round_even #(.WIDTH(24), .SA_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .sa(sa),
    .busy(busy), .done(done), .b(b), .inexact(inexact)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] a;
    logic [4:0]  sa;
    logic [23:0] exp_b;
    logic        exp_inx;
    int          exp_lat;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Reference: exact quotient/remainder of a / 2^sa, then nearest-even.
  function automatic void model(input logic [23:0] ai, input logic [4:0] si,
                                output logic [23:0] eb, output logic einx, output int elat);
    longint q, rem, half;
    q    = longint'(ai) >> si;
    rem  = longint'(ai) - (q << si);
    half = (si == 0) ? 0 : (longint'(1) << (si - 1));
    if (si != 0 && (rem > half || (rem == half && q[0]))) q = q + 1;
    eb   = q[23:0];
    einx = (rem != 0);
    elat = (int'(si) + 1) / 2 + 2;
  endfunction

  // Drive start, then wait (bounded) for done; lat counts edges from the sampling edge.
  task automatic do_op(input logic [23:0] ai, input logic [4:0] si, output int lat);
    start = 1'b1; a = ai; sa = si;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    chk("busy_after_start", busy, 1);
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    logic [23:0] eb, old_b;
    logic        einx;
    int          elat, lat, seen;

    tbl[0] = '{24'h800000,  5'd4, 24'h080000, 1'b0,  4};
    tbl[1] = '{24'hFFFFFF,  5'd1, 24'h800000, 1'b1,  3};
    tbl[2] = '{24'h000003,  5'd2, 24'h000001, 1'b1,  3};
    tbl[3] = '{24'h000002,  5'd2, 24'h000000, 1'b1,  3};
    tbl[4] = '{24'hFFFFFF, 5'd31, 24'h000000, 1'b1, 18};
    tbl[5] = '{24'h123456,  5'd0, 24'h123456, 1'b0,  2};

    rst = 1'b1; start = 1'b0; a = '0; sa = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_b", b, 0);
    chk("rst_inexact", inexact, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      do_op(tbl[i].a, tbl[i].sa, lat);
      chk($sformatf("tbl%0d_done", i), done, 1);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].exp_lat);
      chk($sformatf("tbl%0d_b", i), b, tbl[i].exp_b);
      chk($sformatf("tbl%0d_inexact", i), inexact, tbl[i].exp_inx);
      chk($sformatf("tbl%0d_busy_at_done", i), busy, 0);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_done_pulse", i), done, 0);
      chk($sformatf("tbl%0d_b_hold", i), b, tbl[i].exp_b);
    end

    for (int i = 0; i < 40; i++) begin
      logic [23:0] ra;
      logic [4:0]  rs;
      ra = 24'($urandom);
      rs = 5'($urandom_range(0, 31));
      if (i % 4 == 0) ra = ra >> $urandom_range(0, 20);
      model(ra, rs, eb, einx, elat);
      do_op(ra, rs, lat);
      chk($sformatf("rnd%0d_lat a=%h sa=%0d", i, ra, rs), lat, elat);
      chk($sformatf("rnd%0d_b a=%h sa=%0d", i, ra, rs), b, eb);
      chk($sformatf("rnd%0d_inexact a=%h sa=%0d", i, ra, rs), inexact, einx);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // start while busy is ignored: result and latency belong to the first op
    start = 1'b1; a = 24'h00F0F1; sa = 5'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; a = 24'hFFFFFF; sa = 5'd0;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 4;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    model(24'h00F0F1, 5'd10, eb, einx, elat);
    chk("busy_ignore_lat", lat, elat);
    chk("busy_ignore_b", b, eb);
    chk("busy_ignore_inexact", inexact, einx);
    @(posedge clk); #1;
    chk("busy_ignore_no_second", busy, 0);

    // start in the done cycle is accepted; b holds the old result until the new done
    do_op(24'h000003, 5'd2, lat);
    old_b = b;
    start = 1'b1; a = 24'h400000; sa = 5'd6;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_accepted", busy, 1);
    chk("b2b_b_held", b, old_b);
    lat = 1;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_lat", lat, 5);
    chk("b2b_b", b, 24'h010000);

    // reset mid-SHIFT aborts with no done, outputs cleared
    start = 1'b1; a = 24'hABCDEF; sa = 5'd20;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_b", b, 0);
    chk("abort_inexact", inexact, 0);
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    chk("abort_no_done", seen, 0);
    do_op(24'h800000, 5'd4, lat);
    chk("after_abort_lat", lat, 4);
    chk("after_abort_b", b, 24'h080000);
    chk("after_abort_inexact", inexact, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
